mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_array.sv | 39 +++
 rtl/mem_responder.sv | 155 +++++++++++++++
 tb/tb_mem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory responder.
//   - state_t         : responder FSM state encoding
//   - DEPTH_DEFAULT   : default memory size in 32-bit words
//   - LATENCY_DEFAULT : default wait cycles between accept and response
//   - idx_w()         : word-index width for a given depth
package mem_pkg;

  localparam int DEPTH_DEFAULT   = 128;
  localparam int LATENCY_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int idx_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: word-addressed storage with one synchronous write port,
// one combinational read port and a synchronous clear of every word.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high clear of all words
//   we_i     : write enable
//   waddr_i  : write word index
//   wdata_i  : write data
//   raddr_i  : read word index
//   rdata_o  : read data (0 for an index beyond DEPTH)
module mem_array #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (32'(waddr_i) < 32'(DEPTH))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Guard protects non-power-of-two depths where the index can overrun.
  assign rdata_o = (32'(raddr_i) < 32'(DEPTH)) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with fixed latency.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both 1. The request channel is ready only in
// IDLE; the response channel holds valid/data/err stable until ready.
//
// Ports:
//   clk_i        : clock
//   rst_i        : synchronous active-high reset (also clears the memory)
//   req_valid_i  : request present
//   req_ready_o  : responder can accept a request this cycle
//   req_we_i     : 1 = write, 0 = read
//   req_addr_i   : byte address
//   req_wdata_i  : write data
//   rsp_valid_o  : response available
//   rsp_ready_i  : initiator consumes the response
//   rsp_rdata_o  : read data; 0 for writes and errors
//   rsp_err_o    : request misaligned or out of range
//   dbg_state_o  : current FSM state, for observation
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output state_t      dbg_state_o
);

  localparam int          AW     = idx_w(DEPTH);
  localparam logic [3:0]  LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        enter_resp;
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic        cur_err;
  logic        mem_we;
  logic [31:0] mem_rdata;

  assign accept = (state_q == IDLE) && req_valid_i;

  // With LATENCY=0 RESP is entered on the accept edge itself, before the
  // request has been latched, so the live inputs are used in IDLE.
  assign cur_we    = (state_q == IDLE) ? req_we_i    : we_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr_i  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;
  assign cur_err   = (cur_addr[1:0] != 2'b00) ||
                     ({2'b00, cur_addr[31:2]} >= 32'(DEPTH));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = LAT_M1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory access happens once, on the edge entering RESP.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    if (enter_resp) begin
      err_d   = cur_err;
      rdata_d = (cur_we || cur_err) ? 32'd0 : mem_rdata;
      mem_we  = cur_we && !cur_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (mem_we),
    .waddr_i (cur_addr[AW+1:2]),
    .wdata_i (cur_wdata),
    .raddr_i (cur_addr[AW+1:2]),
    .rdata_o (mem_rdata)
  );

  // Outputs are forced quiet while reset is asserted.
  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign rsp_valid_o = (state_q == RESP) && !rst_i;
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : 32'd0;
  assign rsp_err_o   = rsp_valid_o ? err_q : 1'b0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import mem_pkg::*;

  localparam int DEPTH = 128;
  localparam int LAT   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT0: LATENCY=2
  logic        rst_i, req_valid_i, req_we_i, rsp_ready_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        req_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  state_t      dbg_state_o;

  // DUT1: LATENCY=0
  logic        rst1, req_valid1, req_we1, rsp_ready1;
  logic [31:0] req_addr1, req_wdata1;
  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;
  state_t      dbg_state1;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .dbg_state_o(dbg_state_o)
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_i(rst1),
    .req_valid_i(req_valid1), .req_ready_o(req_ready1),
    .req_we_i(req_we1), .req_addr_i(req_addr1), .req_wdata_i(req_wdata1),
    .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1),
    .rsp_rdata_o(rsp_rdata1), .rsp_err_o(rsp_err1),
    .dbg_state_o(dbg_state1)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];          // {err, rdata}
  logic [31:0] ref_mem [0:DEPTH-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the request rules directly to an array.
  function automatic logic [32:0] model_txn(input logic we, input logic [31:0] addr,
                                             input logic [31:0] wdata);
    int idx;
    idx = int'(addr[31:2]);
    if (addr[1:0] != 2'b00 || addr[31:2] >= 30'(DEPTH)) return {1'b1, 32'd0};
    if (we) begin
      ref_mem[idx] = wdata;
      return {1'b0, 32'd0};
    end
    return {1'b0, ref_mem[idx]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // ---------------- driver (DUT0) ----------------
  // Called #1 after a rising edge. Returns #1 after the handshake edge.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int stall, output logic [31:0] rdata, output logic err);
    int n;
    n = 0;
    while (!req_ready_o && n < 50) begin @(posedge clk); #1; n++; end
    check("req_ready_before_accept", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk); #1;                     // accept edge
    // Scramble the request inputs: only the latched copy may matter.
    req_valid_i = 1'b0; req_we_i = ~we;
    req_addr_i = addr ^ 32'h4; req_wdata_i = $urandom;
    n = 1;
    while (!rsp_valid_o && n < 40) begin
      check("req_ready_low_in_wait", 32'(req_ready_o), 32'd0);
      @(posedge clk); #1; n++;
    end
    check("rsp_latency", 32'(n), 32'(LAT + 1));
    rdata = rsp_rdata_o;
    err   = rsp_err_o;
    for (int s = 0; s < stall; s++) begin
      rsp_ready_i = 1'b0;
      @(posedge clk); #1;
      check("stall_valid", 32'(rsp_valid_o), 32'd1);
      check("stall_rdata", rsp_rdata_o, rdata);
      check("stall_err", 32'(rsp_err_o), 32'(err));
      check("stall_req_ready", 32'(req_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;                     // handshake edge
    rsp_ready_i = 1'b0;
    check("idle_after_handshake", 32'(dbg_state_o), 32'(IDLE));
    check("ready_after_handshake", 32'(req_ready_o), 32'd1);
    check("valid_low_after_handshake", 32'(rsp_valid_o), 32'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [32:0] e;
    int          n;

    rst_i = 1'b1; req_valid_i = 0; req_we_i = 0; req_addr_i = 0; req_wdata_i = 0;
    rsp_ready_i = 0;
    rst1 = 1'b1; req_valid1 = 0; req_we1 = 0; req_addr1 = 0; req_wdata1 = 0;
    rsp_ready1 = 0;
    model_clear();

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 32'h13,  32'h0,        0, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 32'h200, 32'h00000BAD, 0, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,   32'h0,        0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h1FC, 32'h0,        0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h1FC, 32'hCAFEF00D, 1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h1FC, 32'h0,        5, 1'b0, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 32'h40,  32'h11111111, 0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 32'h44,  32'h22222222, 0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h40,  32'h0,        2, 1'b0, 32'h11111111};
    vecs[11] = '{1'b1, 32'h12,  32'h55555555, 0, 1'b1, 32'h0};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    rst_i = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready_o), 32'd1);
    check("post_rst_state", 32'(dbg_state_o), 32'(IDLE));
    @(posedge clk); #1;

    // ---- table vectors ----
    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].stall, rd, er);
      e = model_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end
    txn(1'b0, 32'h10, 32'h0, 0, rd, er);
    check("misaligned_write_no_effect", rd, 32'hDEADBEEF);
    void'(model_txn(1'b0, 32'h10, 32'h0));

    // ---- reset in WAIT of a write ----
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h20; req_wdata_i = 32'h1234;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("in_wait_before_reset", 32'(dbg_state_o), 32'(WAIT));
    rst_i = 1'b1;
    #1;
    check("rst_mid_req_ready", 32'(req_ready_o), 32'd0);
    check("rst_mid_rsp_valid", 32'(rsp_valid_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    #1;
    check("rst_mid_idle", 32'(dbg_state_o), 32'(IDLE));
    check("rst_mid_ready", 32'(req_ready_o), 32'd1);
    model_clear();
    n = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(posedge clk); #1;
      if (rsp_valid_o) n++;
    end
    check("rst_mid_no_response", 32'(n), 32'd0);
    txn(1'b0, 32'h20, 32'h0, 0, rd, er);
    check("rst_mid_no_write", rd, 32'h0);
    check("rst_mid_read_err", 32'(er), 32'd0);

    // ---- randomized phase against reference model ----
    for (int i = 0; i < 150; i++) begin
      logic        we;
      logic [31:0] addr, wdata;
      we    = 1'($urandom_range(0, 1));
      addr  = 32'($urandom_range(0, DEPTH * 4 + 15));
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      if ($urandom_range(0, 2) == 0) addr = 32'($urandom_range(0, 7)) << 2;
      wdata = $urandom;
      exp_q.push_back(model_txn(we, addr, wdata));
      txn(we, addr, wdata, $urandom_range(0, 3), rd, er);
      e = exp_q.pop_front();
      check($sformatf("rand%0d_a%08h", i, addr), {er, rd} == e ? 32'd1 : 32'd0, 32'd1);
    end

    // ---- LATENCY=0 instance: back-to-back with valid held high ----
    rst1 = 1'b0;
    model_clear();
    req_valid1 = 1'b1; rsp_ready1 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [32:0] e1;
      req_we1    = (k < 8);
      req_addr1  = 32'((k % 8) * 4);
      req_wdata1 = 32'hA5000000 + 32'(k * 3 + 1);
      e1 = model_txn(req_we1, req_addr1, req_wdata1);
      #1;
      check($sformatf("l0_ready%0d", k), 32'(req_ready1), 32'd1);
      @(posedge clk); #1;               // accept edge
      check($sformatf("l0_valid%0d", k), 32'(rsp_valid1), 32'd1);
      check($sformatf("l0_noready%0d", k), 32'(req_ready1), 32'd0);
      check($sformatf("l0_rdata%0d", k), rsp_rdata1, e1[31:0]);
      check($sformatf("l0_err%0d", k), 32'(rsp_err1), 32'(e1[32]));
      @(posedge clk);                   // handshake edge
    end
    #1;
    req_valid1 = 1'b0; rsp_ready1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
